// File: rtl/mem_access_master_pkg.sv
// Shared definitions for the memory access master: FSM state encoding
// and the address/data widths common with the single-port memory.
package mem_access_master_pkg;

  localparam int MEM_ADDR_WIDTH = 4;
  localparam int MEM_DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    CAPT  = 3'd3,
    CLR   = 3'd4,
    RESP  = 3'd5
  } state_e;

endpackage

// File: rtl/mem_access_master.sv
// Single-outstanding initiator for the synchronous single-port memory.
// Optional write loopback compare is built with WR_LOOPBACK_CHECK_EN.
module mem_access_master
  import mem_access_master_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [CNT_WIDTH-1:0]  txn_count,
  output logic                  mem_en,
  output logic                  mem_rd_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_error,
  output logic                  mem_err_clr,
  output logic                  mem_out_wr_data_en,
  input  logic [DATA_WIDTH-1:0] mem_out_wr_data
);

  state_e                state;
  state_e                state_n;
  logic                  ready_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  mem_error_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  accept;
  logic                  edge_hit;
  logic                  lb_hit;
  logic                  err_hit;

  assign accept = req_valid & ready_q;

  // Only a rising edge seen while our transaction is in flight counts.
  assign edge_hit = mem_error & ~mem_error_q &
                    (state inside {ISSUE, WAIT, CAPT});

`ifdef WR_LOOPBACK_CHECK_EN
  assign lb_hit = (state == CAPT) & wr_q &
                  (mem_out_wr_data != wdata_q);
`else
  logic unused_lb;
  assign unused_lb = ^mem_out_wr_data;
  assign lb_hit    = 1'b0;
`endif

  assign err_hit = edge_hit | lb_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    state_n = CAPT;
      CAPT:    state_n = (err_q | err_hit) ? CLR : RESP;
      CLR:     state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q     <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_error_q <= 1'b0;
      count_q     <= '0;
    end else begin
      ready_q     <= (state_n == IDLE);
      mem_error_q <= mem_error;
      if (state == IDLE) begin
        err_q <= 1'b0;
        if (accept) begin
          wr_q    <= req_wr;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
        end
      end else if (err_hit) begin
        err_q <= 1'b1;
      end
      if (state == CAPT) begin
        rdata_q <= wr_q ? '0 : mem_rd_data;
      end
      if (state == RESP && rsp_ready) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  always_comb begin
    mem_en             = (state == ISSUE);
    mem_err_clr        = (state == CLR);
    rsp_valid          = (state == RESP);
    rsp_err            = err_q & (state == RESP);
    mem_out_wr_data_en = 1'b0;
`ifdef WR_LOOPBACK_CHECK_EN
    mem_out_wr_data_en = wr_q & (state inside {ISSUE, WAIT});
`endif
  end

  assign req_ready   = ready_q;
  assign mem_rd_wr   = wr_q;
  assign mem_addr    = addr_q;
  assign mem_wr_data = wdata_q;
  assign rsp_rdata   = rdata_q;
  assign txn_count   = count_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Randomised and directed bench for mem_access_master against a
// transaction-level model of the memory and the expected responses.
module tb_mem_access_master;

`ifdef WR_LOOPBACK_CHECK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_wr, rsp_ready;
  logic [3:0]  req_addr;
  logic [15:0] req_wdata;
  logic        mem_error;
  logic [15:0] lb_flip;
  logic [15:0] mem_rd_data = '0;
  logic [15:0] mem_out_wr_data;

  logic        req_ready, rsp_valid, rsp_err;
  logic [15:0] rsp_rdata, txn_count;
  logic        mem_en, mem_rd_wr, mem_err_clr, mem_out_wr_data_en;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wr_data;

  logic        req_ready_4, rsp_valid_4, rsp_err_4;
  logic [15:0] rsp_rdata_4;
  logic [3:0]  txn_count_4;
  logic        mem_en_4, mem_rd_wr_4, mem_err_clr_4, mem_out_wr_data_en_4;
  logic [3:0]  mem_addr_4;
  logic [15:0] mem_wr_data_4;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt   = 0;
  logic [15:0] ref_mem [16];
  logic [15:0] mem [16] = '{default: 16'h0};

  always #5 clk = ~clk;

  assign mem_out_wr_data = mem_wr_data ^ lb_flip;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_rd_wr) mem[mem_addr] <= mem_wr_data;
      else           mem_rd_data   <= mem[mem_addr];
    end
  end

  mem_access_master dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .txn_count(txn_count),
    .mem_en(mem_en), .mem_rd_wr(mem_rd_wr), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .mem_error(mem_error), .mem_err_clr(mem_err_clr),
    .mem_out_wr_data_en(mem_out_wr_data_en),
    .mem_out_wr_data(mem_out_wr_data)
  );

  mem_access_master #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready_4),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_4), .rsp_err(rsp_err_4),
    .txn_count(txn_count_4),
    .mem_en(mem_en_4), .mem_rd_wr(mem_rd_wr_4), .mem_addr(mem_addr_4),
    .mem_wr_data(mem_wr_data_4), .mem_rd_data(mem_rd_data),
    .mem_error(mem_error), .mem_err_clr(mem_err_clr_4),
    .mem_out_wr_data_en(mem_out_wr_data_en_4),
    .mem_out_wr_data(mem_out_wr_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit wr, input logic [3:0] a,
                       input logic [15:0] d);
    int w = 0;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    while (!req_ready && w < 20) begin
      tick();
      w++;
    end
    chk("req_ready_wait", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic finish_txn(input bit wr, input logic [3:0] a,
                            input logic [15:0] d, input int delay,
                            input bit inject, input bit mism);
    int n, en_c, clr_c, lb_c, lat;
    bit ee;
    logic [15:0] er;
    ee  = inject | (LB & wr & mism);
    lat = ee ? 5 : 4;
    er  = wr ? 16'h0 : ref_mem[a];
    chk("issue_en", mem_en, 1);
    chk("issue_cmd", {mem_rd_wr, mem_addr, mem_wr_data}, {wr, a, d});
    n = 1; en_c = 0; clr_c = 0; lb_c = 0;
    while (!rsp_valid && n < 12) begin
      en_c  += int'(mem_en);
      clr_c += int'(mem_err_clr);
      lb_c  += int'(mem_out_wr_data_en);
      tick();
      n++;
      if (n == 2 && inject) mem_error = 1'b1;
    end
    chk("latency", n, lat);
    chk("mem_en_pulses", en_c, 1);
    chk("err_clr_pulses", clr_c, int'(ee));
    chk("lb_en_cycles", lb_c, (LB && wr) ? 2 : 0);
    for (int i = 0; i < delay; i++) begin
      chk("rsp_hold", {rsp_valid, req_ready, rsp_rdata, rsp_err},
          {1'b1, 1'b0, er, ee});
      tick();
    end
    chk("rsp_data", {rsp_valid, rsp_rdata, rsp_err}, {1'b1, er, ee});
    chk("dut4_mirror",
        {req_ready_4, rsp_valid_4, rsp_err_4, rsp_rdata_4, mem_en_4,
         mem_rd_wr_4, mem_addr_4, mem_wr_data_4, mem_err_clr_4,
         mem_out_wr_data_en_4},
        {req_ready, rsp_valid, rsp_err, rsp_rdata, mem_en,
         mem_rd_wr, mem_addr, mem_wr_data, mem_err_clr,
         mem_out_wr_data_en});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cnt++;
    if (wr) ref_mem[a] = d;
    chk("rsp_drop", {rsp_valid, req_ready}, 2'b01);
    chk("txn_count", txn_count, cnt % 65536);
    chk("txn_count_4", txn_count_4, cnt % 16);
  endtask

  initial begin
    bit          wr, inj, mism, seen;
    logic [3:0]  a;
    logic [15:0] d;
    int          dly;
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0;
    reset = 1'b1; req_valid = 0; req_wr = 0; req_addr = '0;
    req_wdata = '0; rsp_ready = 0; mem_error = 0; lb_flip = '0;
    #1;
    chk("reset_outputs",
        {req_ready, rsp_valid, rsp_err, rsp_rdata, txn_count, mem_en,
         mem_rd_wr, mem_addr, mem_wr_data, mem_err_clr,
         mem_out_wr_data_en}, '0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    tick();
    chk("ready_after_reset", req_ready, 1);

    issue(1, 4'd3, 16'hA5A5);
    finish_txn(1, 4'd3, 16'hA5A5, 0, 0, 0);
    issue(0, 4'd3, 16'h0);
    finish_txn(0, 4'd3, 16'h0, 0, 0, 0);
    chk("two_txns", txn_count, 2);

    // Back-to-back: next request stays valid while the response stalls.
    issue(1, 4'd9, 16'h1111);
    req_wr = 0; req_addr = 4'd9; req_wdata = 16'h0; req_valid = 1'b1;
    finish_txn(1, 4'd9, 16'h1111, 3, 0, 0);
    tick();
    req_valid = 1'b0;
    finish_txn(0, 4'd9, 16'h0, 0, 0, 0);

    issue(0, 4'd7, 16'h0);
    finish_txn(0, 4'd7, 16'h0, 1, 1, 0);
    issue(1, 4'd7, 16'h7777);
    finish_txn(1, 4'd7, 16'h7777, 0, 0, 0);
    mem_error = 1'b0;
    tick();

    lb_flip = 16'h0001;
    issue(1, 4'd2, 16'h1235);
    chk("lb_value", mem_out_wr_data, 16'h1234);
    finish_txn(1, 4'd2, 16'h1235, 0, 0, 1);
    lb_flip = 16'h0000;
    issue(1, 4'd2, 16'h1235);
    finish_txn(1, 4'd2, 16'h1235, 0, 0, 0);

    for (int k = 0; k < 24; k++) begin
      wr   = 1'($urandom_range(0, 1));
      a    = 4'($urandom_range(0, 15));
      d    = 16'($urandom);
      dly  = $urandom_range(0, 3);
      inj  = ($urandom_range(0, 3) == 0);
      mism = 1'($urandom_range(0, 1));
      lb_flip = mism ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
      issue(wr, a, d);
      finish_txn(wr, a, d, dly, inj, mism);
      mem_error = 1'b0;
      lb_flip   = 16'h0;
      tick();
    end

    issue(0, 4'd5, 16'h0);
    tick();
    reset = 1'b1;
    #1;
    chk("reset_mid_txn",
        {req_ready, rsp_valid, rsp_err, rsp_rdata, mem_en, mem_rd_wr,
         mem_addr, mem_wr_data, mem_err_clr, mem_out_wr_data_en}, '0);
    chk("reset_count", {txn_count, txn_count_4}, '0);
    #2 reset = 1'b0;
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen |= rsp_valid;
    end
    chk("no_rsp_after_reset", seen, 0);
    chk("ready_after_abort", req_ready, 1);

    for (int k = 0; k < 17; k++) begin
      a = 4'($urandom_range(0, 15));
      issue(0, a, 16'h0);
      finish_txn(0, a, 16'h0, 0, 0, 0);
    end
    chk("wrap_count_16", txn_count, 17);
    chk("wrap_count_4", txn_count_4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_master.md
Name: mem_access_master

Overview:
- Initiator for the synchronous single-port memory interface (en / rd_wr / addr / wr_data / rd_data / error / err_clr).
- Accepts one host request at a time over a valid/ready handshake and sequences the memory's IDLE -> transaction -> IDLE timing.
- Returns read data, or a write completion, over a valid/ready response channel.
- Sits between any host engine and one memory instance.

Parameters:
- ADDR_WIDTH, 4, memory address width
- DATA_WIDTH, 16, memory data width
- CNT_WIDTH, 16, width of completed-transaction counter

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  host request valid
- req_ready  out  1  master can accept a request
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_err  out  1  transaction saw a new memory error
- txn_count  out  CNT_WIDTH  completed responses, wraps
- mem_en  out  1  memory enable
- mem_rd_wr  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wr_data  out  DATA_WIDTH  memory write data
- mem_rd_data  in  DATA_WIDTH  memory read data
- mem_error  in  1  memory error level
- mem_err_clr  out  1  memory error clear pulse
- mem_out_wr_data_en  out  1  write loopback enable
- mem_out_wr_data  in  DATA_WIDTH  looped-back write data

Behaviour:
- Reset clears every register and output to 0, and sets state to IDLE. This includes req_ready and mem_* outputs; req_ready goes to 1 the first cycle after reset deasserts. Reset mid-transaction aborts it, with no response.
- States: IDLE, ISSUE, WAIT, CAPT, CLR, RESP. All outputs are registered or decoded from state only.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch wr/addr/wdata and go to ISSUE.
  - Clear the per-transaction err flag.
- ISSUE:
  - mem_en = 1; mem_rd_wr = latched wr; mem_addr/mem_wr_data driven from latches.
  - Always go to WAIT.
- WAIT:
  - mem_en = 0, so the memory does not re-fire on its return to IDLE; addr/data held.
  - Memory performs its write/read on this edge. Go to CAPT.
- CAPT:
  - For a read, latch mem_rd_data into rsp_rdata; for a write, rsp_rdata = 0.
  - If the err flag is set, go to CLR; else go to RESP.
- CLR: mem_err_clr = 1 for exactly one cycle, then go to RESP.
- RESP:
  - rsp_valid = 1; rsp_rdata/rsp_err stable until rsp_ready.
  - On rsp_ready, increment txn_count (mod 2^CNT_WIDTH) and go to IDLE.
  - rsp_ready is ignored in other states.
- Error detection:
  - Register mem_error_q.
  - Set the err flag if mem_error & ~mem_error_q in any of ISSUE/WAIT/CAPT.
  - A level that is high before ISSUE is not attributed to the new transaction.
- Latency: request accept to rsp_valid is 4 cycles, or 5 with CLR. req_ready is low from the accept cycle until return to IDLE, so there is at most one outstanding transaction.
- Width rules: address and data pass through unmodified; no address range check in the master.

Optional Feature:
- Macro WR_LOOPBACK_CHECK_EN.
- Defined:
  - On writes, mem_out_wr_data_en = 1 during ISSUE and WAIT.
  - In CAPT, if mem_out_wr_data != latched wdata, set the err flag.
  - Reads are unaffected.
- Undefined: mem_out_wr_data_en is tied to 0, mem_out_wr_data is ignored, and no compare logic is built.

Decomposition:
- Shared package: state encoding constants (IDLE = 0 .. RESP = 5, 3 bits), plus the ADDR_WIDTH/DATA_WIDTH defaults shared with the memory block.
- No sub-module; the single FSM plus datapath latches stay flat.

Test Plan:
- Write then read: write 0xA5A5 @ addr 3, then read addr 3 -> mem_en high one cycle per transaction; rsp_valid 4 cycles after each accept; rsp_rdata = 0xA5A5; rsp_err = 0; txn_count = 2.
- Back-to-back with backpressure: req_valid held, rsp_ready low 3 cycles -> rsp_valid and rsp_rdata stable; req_ready stays 0 until rsp_ready; second request accepted the cycle after return to IDLE.
- Error edge: force mem_error 0->1 during WAIT of a read @ addr 7 -> mem_err_clr pulses one cycle; rsp_err = 1; rsp_valid at cycle 5 after accept. The next transaction with mem_error held high gives rsp_err = 0.
- Reset mid-operation: assert reset in WAIT -> all outputs 0 the same cycle; no rsp_valid afterward; txn_count = 0.
- Counter wrap: CNT_WIDTH = 4, 17 reads -> txn_count = 1.
- WR_LOOPBACK_CHECK_EN defined, memory loopback returning 0x1234 for a write of 0x1235 -> mem_out_wr_data_en high in ISSUE/WAIT; rsp_err = 1. A matching value gives rsp_err = 0.
